// File: rtl/tictactoe_turn_ctrl.sv
// Tic-tac-toe turn/board controller: human X moves, machine O moves,
// player timeout auto-move, win/draw detection.
module tictactoe_turn_ctrl #(
    parameter int TIMEOUT_CYCLES = 500,
    parameter int CPU_DELAY      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] move_cell,
    input  logic [3:0] random,
    output logic [8:0] Xcells,
    output logic [8:0] Ocells,
    output logic       x_turn,
    output logic       move_err,
    output logic [1:0] winner,
    output logic       game_over
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int DW = (CPU_DELAY > 1) ? $clog2(CPU_DELAY) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0] DMAX = DW'(CPU_DELAY - 1);

    typedef enum logic [2:0] {
        PLAYER,
        CHECK_X,
        CPU_WAIT,
        CPU_MOVE,
        CHECK_O,
        OVER
    } state_t;

    state_t        state, state_n;
    logic [8:0]    xb, xb_n;
    logic [8:0]    ob, ob_n;
    logic [TW-1:0] timer, timer_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [1:0]    win_n;
    logic          err_n;
    logic [8:0]    free;
    logic [8:0]    req;

    function automatic logic has_line(input logic [8:0] b);
        return (&b[2:0]) | (&b[5:3]) | (&b[8:6])
             | (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7])
             | (b[2] & b[5] & b[8])
             | (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    function automatic logic [8:0] cell_mask(input logic [3:0] idx);
        return (idx < 4'd9) ? (9'd1 << idx) : 9'd0;
    endfunction

    // Preferred cell if it is legal, otherwise the lowest free cell.
    function automatic logic [8:0] pick(input logic [3:0] idx,
                                        input logic [8:0] f);
        logic [8:0] want;
        want = cell_mask(idx) & f;
        return (|want) ? want : (f & (~f + 9'd1));
    endfunction

    assign free = ~(xb | ob);
    assign req  = cell_mask(move_cell) & free;

    always_comb begin
        state_n = state;
        xb_n    = xb;
        ob_n    = ob;
        timer_n = timer;
        dcnt_n  = dcnt;
        win_n   = winner;
        err_n   = 1'b0;
        if (new_game) begin
            state_n = PLAYER;
            xb_n    = '0;
            ob_n    = '0;
            timer_n = '0;
            dcnt_n  = '0;
            win_n   = 2'b00;
        end else begin
            unique case (state)
                PLAYER: begin
                    timer_n = timer + 1'b1;
                    if (move_valid && |req) begin
                        xb_n    = xb | req;
                        state_n = CHECK_X;
                    end else begin
                        err_n = move_valid;
                        if (timer == TMAX) begin
                            xb_n    = xb | pick(random, free);
                            state_n = CHECK_X;
                        end
                    end
                end
                CHECK_X: begin
                    if (has_line(xb)) begin
                        win_n   = 2'b01;
                        state_n = OVER;
                    end else if (free == 9'd0) begin
                        win_n   = 2'b11;
                        state_n = OVER;
                    end else begin
                        dcnt_n  = '0;
                        state_n = CPU_WAIT;
                    end
                end
                CPU_WAIT: begin
                    if (dcnt == DMAX) state_n = CPU_MOVE;
                    else              dcnt_n  = dcnt + 1'b1;
                end
                CPU_MOVE: begin
                    ob_n    = ob | pick(random, free);
                    state_n = CHECK_O;
                end
                CHECK_O: begin
                    if (has_line(ob)) begin
                        win_n   = 2'b10;
                        state_n = OVER;
                    end else if (free == 9'd0) begin
                        win_n   = 2'b11;
                        state_n = OVER;
                    end else begin
                        timer_n = '0;
                        state_n = PLAYER;
                    end
                end
                OVER: begin
                end
                default: state_n = PLAYER;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= PLAYER;
            xb        <= '0;
            ob        <= '0;
            timer     <= '0;
            dcnt      <= '0;
            winner    <= 2'b00;
            move_err  <= 1'b0;
            x_turn    <= 1'b1;
            game_over <= 1'b0;
        end else begin
            state     <= state_n;
            xb        <= xb_n;
            ob        <= ob_n;
            timer     <= timer_n;
            dcnt      <= dcnt_n;
            winner    <= win_n;
            move_err  <= err_n;
            x_turn    <= (state_n == PLAYER);
            game_over <= (state_n == OVER);
        end
    end

    assign Xcells = xb;
    assign Ocells = ob;

endmodule
